// File: rtl/decoder_pulse.sv
// rtl/decoder_pulse.sv - FIFO-buffered 2-to-4 one-hot decoder emitting timed pulses
module decoder_pulse #(
  parameter int PULSE_LEN = 3,
  parameter int GAP_LEN   = 1,
  parameter int DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [1:0] in_code,
  output logic       in_ready,
  output logic [3:0] out,
  output logic       out_valid,
  output logic       busy,
  output logic [2:0] count
);

  localparam int         PW       = $clog2(DEPTH);
  localparam logic [3:0] LP_PULSE = 4'(PULSE_LEN - 1);
  localparam logic [3:0] LP_GAP   = 4'(GAP_LEN - 1);
  localparam logic [2:0] LP_DEPTH = 3'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_GAP} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_cnt;
  logic [3:0]      w_cnt_nxt;
  logic [3:0]      r_out;
  logic [3:0]      w_out_nxt;
  logic            r_valid;
  logic            w_valid_nxt;

  logic [1:0]      r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [2:0]      r_count;
  logic            w_push;
  logic            w_pop;
  logic [1:0]      w_head;
  logic [3:0]      w_head_onehot;

  assign in_ready      = (r_count < LP_DEPTH) && !rst;
  assign w_push        = in_valid && in_ready;
  assign w_head        = r_mem[r_rptr];
  assign w_head_onehot = 4'd1 << w_head;

  assign out       = r_out;
  assign out_valid = r_valid;
  assign count     = r_count;
  assign busy      = (r_state != ST_IDLE) || (r_count != 3'd0);

  // Next-state logic: pops the FIFO head when a new pulse is launched
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_out_nxt   = r_out;
    w_valid_nxt = r_valid;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_out_nxt   = 4'd0;
        w_valid_nxt = 1'b0;
        if (r_count != 3'd0) begin
          w_pop       = 1'b1;
          w_out_nxt   = w_head_onehot;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = LP_PULSE;
          w_state_nxt = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else if (GAP_LEN > 0) begin
          w_out_nxt   = 4'd0;
          w_valid_nxt = 1'b0;
          w_cnt_nxt   = LP_GAP;
          w_state_nxt = ST_GAP;
        end else if (r_count != 3'd0) begin
          // No gap configured: chain straight into the next pulse
          w_pop       = 1'b1;
          w_out_nxt   = w_head_onehot;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = LP_PULSE;
        end else begin
          w_out_nxt   = 4'd0;
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GAP: begin
        w_out_nxt   = 4'd0;
        w_valid_nxt = 1'b0;
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_out_nxt   = 4'd0;
        w_valid_nxt = 1'b0;
        w_cnt_nxt   = 4'd0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM and output registers; reset aborts any pulse or gap in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_out   <= 4'd0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  // FIFO storage; writes are already blocked during reset through in_ready
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= in_code;
    end
  end

  // FIFO pointers and occupancy; reset discards queued codes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= 3'd0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 3'd1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 3'd1;
      end
    end
  end

endmodule

// File: doc/decoder_pulse.md
DECODER_PULSE -- requirements
Module: decoder_pulse

Interface
REQ-001 SHALL have parameter PULSE_LEN, default 3, cycles each one-hot code is driven (legal 1..15).
REQ-002 SHALL have parameter GAP_LEN, default 1, idle cycles between consecutive pulses (legal 0..15).
REQ-003 SHALL have parameter DEPTH, default 4, input FIFO entries (power of 2, >=2).
REQ-004 SHALL have port clk  input  1  rising-edge clock; the single clock of the block.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  in_code presented.
REQ-007 SHALL have port in_code  input  2  binary index to decode.
REQ-008 SHALL have port in_ready  output  1  FIFO can accept a code.
REQ-009 SHALL have port out  output  4  registered one-hot decode; 4'b0000 when not driving.
REQ-010 SHALL have port out_valid  output  1  out holds a valid one-hot code.
REQ-011 SHALL have port busy  output  1  state != IDLE or FIFO non-empty.
REQ-012 SHALL have port count  output  3  FIFO occupancy, 0..DEPTH.

Function
REQ-013 SHALL accept a code at a rising edge where in_valid && in_ready; in_ready = (count < DEPTH) && !rst.
REQ-014 SHALL store accepted codes in a DEPTH-entry FIFO, read/write pointers wrapping modulo DEPTH; output order equals acceptance order; no loss, no duplication.
REQ-015 SHALL, on simultaneous push and pop, leave count unchanged and perform both.
REQ-016 SHALL ignore in_code whenever in_valid is low or in_ready is low.
REQ-017 SHALL implement FSM states IDLE, DRIVE, GAP.
REQ-018 IDLE: out=4'b0000, out_valid=0; if count>0, pop head, load out <= 1<<code, out_valid <= 1, load counter PULSE_LEN-1, go DRIVE.
REQ-019 DRIVE: hold out/out_valid; decrement counter each cycle; at counter==0 exit per REQ-020..022.
REQ-020 DRIVE exit with GAP_LEN>0: out<=0, out_valid<=0, counter<=GAP_LEN-1, go GAP.
REQ-021 DRIVE exit with GAP_LEN==0 and count>0: pop head, load new one-hot, counter<=PULSE_LEN-1, stay DRIVE (out_valid stays high).
REQ-022 DRIVE exit with GAP_LEN==0 and count==0: out<=0, out_valid<=0, go IDLE.
REQ-023 GAP: outputs zero; decrement counter; at counter==0 go IDLE.
REQ-024 SHALL produce out_valid high for exactly PULSE_LEN consecutive cycles per accepted code.
REQ-025 Latency: code accepted at edge T into empty FIFO with FSM in IDLE SHALL have out_valid high starting at edge T+1.
REQ-026 Minimum spacing between the first cycles of consecutive pulses SHALL be PULSE_LEN+GAP_LEN+1 cycles when GAP_LEN>0 (GAP -> IDLE -> DRIVE), PULSE_LEN when GAP_LEN==0.
REQ-027 out SHALL never have more than one bit set; out_valid==1 iff out != 0.

Reset
REQ-028 While rst is high at a rising edge: state<=IDLE, out<=4'b0000, out_valid<=0, count<=0, pointers<=0, counter<=0; FIFO contents discarded.
REQ-029 Reset asserted mid-pulse or mid-gap SHALL abort immediately; no queued code is output afterwards.
REQ-030 in_ready SHALL be 0 while rst is high and 1 in the first cycle after rst deasserts.

Verification
REQ-031 Defaults; push code 2 at edge 1 -> out=4'b0100, out_valid=1 at edges 2,3,4; out=0 at edge 5; busy=0 from edge 6.
REQ-032 Defaults; push codes 0,1,2,3 on edges 1..4 -> pulses 0001,0010,0100,1000 each 3 cycles, each separated by 2 zero cycles; count peaks below 4; in_ready stays 1.
REQ-033 Defaults; hold in_valid high with 8 codes -> in_ready drops when count==4, rises after a pop; all 8 codes output in order exactly once.
REQ-034 Defaults; push codes 1,3; assert rst during first pulse's second cycle -> out=0, out_valid=0, count=0 at next edge; code 3 never appears.
REQ-035 PULSE_LEN=1, GAP_LEN=0; push 3,0 on edges 1,2 -> out=1000 at edge 2, 0001 at edge 3, out_valid high both cycles, 0 at edge 4.
REQ-036 Defaults; with count==1 and FSM popping, push simultaneously -> count remains 1, both codes output in order.
